// File: rtl/pu_ctrl_pkg.sv
// Shared types for the PU load controller: FSM state encoding and memory namespace ids.
// Imported by the interface and the pu_load_ctrl top.
package pu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } pu_state_e;

    localparam logic [1:0] NS_INST   = 2'd0;
    localparam logic [1:0] NS_DATA   = 2'd1;
    localparam logic [1:0] NS_WEIGHT = 2'd2;
    localparam logic [1:0] NS_META   = 2'd3;

    function automatic int ctrl_width(input int log_pe_cols, input int pu_cols);
        return (log_pe_cols + 1) * pu_cols;
    endfunction

endpackage

// File: rtl/pu_load_ctrl_if.sv
// Host/PU-facing bundle of pu_load_ctrl: descriptor and write-data streams, run control, PU memory port.
// slave = controller side, master = host + PU side.
interface pu_load_ctrl_if
    import pu_ctrl_pkg::*;
#(
    parameter int memDataLen        = 16,
    parameter int numPuMemColumns   = 2,
    parameter int logNumPeMemColumn = 2,
    parameter int logMemNamespaces  = 2,
    parameter int countLen          = 12
);
    localparam int memDataLenIn = memDataLen * numPuMemColumns;
    localparam int memCtrlIn    = ctrl_width(logNumPeMemColumn, numPuMemColumns);

    // valid/ready: a transfer happens on a rising clk edge where both are high;
    // a source holds valid and its payload stable until that edge.
    logic                        desc_valid;
    logic                        desc_ready;
    logic [memCtrlIn-1:0]        desc_ctrl;
    logic [logMemNamespaces-1:0] desc_type;
    logic [countLen-1:0]         desc_len;

    logic                        wr_valid;
    logic                        wr_ready;
    logic [memDataLenIn-1:0]     wr_data;

    logic                        go;
    logic                        busy;
    logic                        done;
    logic                        err;

    logic [memCtrlIn-1:0]        ctrl_mem_in;
    logic [logMemNamespaces-1:0] mem_data_type;
    logic [memDataLenIn-1:0]     mem_data_input;
    logic                        start;
    logic                        inst_eoc;

    modport slave (
        input  desc_valid, desc_ctrl, desc_type, desc_len,
        input  wr_valid, wr_data, go, inst_eoc,
        output desc_ready, wr_ready, busy, done, err,
        output ctrl_mem_in, mem_data_type, mem_data_input, start
    );

    modport master (
        output desc_valid, desc_ctrl, desc_type, desc_len,
        output wr_valid, wr_data, go, inst_eoc,
        input  desc_ready, wr_ready, busy, done, err,
        input  ctrl_mem_in, mem_data_type, mem_data_input, start
    );

endinterface

// File: rtl/pu_load_ctrl.sv
// Streams descriptor-framed words into PU memory columns, then starts the PU and waits for end-of-compute.
// Optional RUN watchdog enabled by defining PU_LOAD_CTRL_TIMEOUT_EN.
module pu_load_ctrl
    import pu_ctrl_pkg::*;
#(
    parameter int memDataLen        = 16,
    parameter int numPuMemColumns   = 2,
    parameter int logNumPeMemColumn = 2,
    parameter int logMemNamespaces  = 2,
    parameter int countLen          = 12,
    parameter int timeoutCycles     = 4095
) (
    input  logic          clk,
    input  logic          reset,
    pu_load_ctrl_if.slave bus,
    output pu_state_e     dbg_state_o
);
    localparam int memDataLenIn = memDataLen * numPuMemColumns;
    localparam int memCtrlIn    = ctrl_width(logNumPeMemColumn, numPuMemColumns);

    pu_state_e                   state_q, state_d;
    logic [memCtrlIn-1:0]        ctrl_lat_q, ctrl_lat_d;
    logic [logMemNamespaces-1:0] type_lat_q, type_lat_d;
    logic [countLen-1:0]         count_q, count_d;
    logic [memCtrlIn-1:0]        ctrl_out_q, ctrl_out_d;
    logic [logMemNamespaces-1:0] type_out_q, type_out_d;
    logic [memDataLenIn-1:0]     data_out_q, data_out_d;
    logic                        wr_accept;

`ifdef PU_LOAD_CTRL_TIMEOUT_EN
    localparam int WdogW = (timeoutCycles > 1) ? $clog2(timeoutCycles) : 1;
    localparam logic [WdogW-1:0] WdogLast = WdogW'(timeoutCycles - 1);
    logic [WdogW-1:0] wdog_q, wdog_d;
    logic             err_q, err_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (timeoutCycles != 0);
`endif

    assign wr_accept = (state_q == ST_LOAD) && bus.wr_valid;

    always_comb begin
        state_d    = state_q;
        ctrl_lat_d = ctrl_lat_q;
        type_lat_d = type_lat_q;
        count_d    = count_q;
`ifdef PU_LOAD_CTRL_TIMEOUT_EN
        wdog_d     = wdog_q;
        err_d      = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // A pending descriptor takes priority; go is looked at again next IDLE cycle.
                if (bus.desc_valid) begin
                    ctrl_lat_d = bus.desc_ctrl;
                    type_lat_d = bus.desc_type;
                    count_d    = bus.desc_len;
                    if (bus.desc_len != '0) state_d = ST_LOAD;
                end else if (bus.go) begin
                    state_d = ST_START;
`ifdef PU_LOAD_CTRL_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ST_LOAD: begin
                if (wr_accept) begin
                    count_d = count_q - countLen'(1);
                    if (count_q == countLen'(1)) state_d = ST_IDLE;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
`ifdef PU_LOAD_CTRL_TIMEOUT_EN
                wdog_d  = '0;
`endif
            end
            ST_RUN: begin
                if (bus.inst_eoc) begin
                    state_d = ST_DONE;
`ifdef PU_LOAD_CTRL_TIMEOUT_EN
                end else if (wdog_q == WdogLast) begin
                    state_d = ST_DONE;
                    err_d   = 1'b1;
                end else begin
                    wdog_d  = wdog_q + WdogW'(1);
`endif
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Write port is a one-cycle echo of the accepted word; idle cycles drive no column select.
    always_comb begin
        ctrl_out_d = '0;
        type_out_d = type_out_q;
        data_out_d = data_out_q;
        if (wr_accept) begin
            ctrl_out_d = ctrl_lat_q;
            type_out_d = type_lat_q;
            data_out_d = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            ctrl_lat_q <= '0;
            type_lat_q <= '0;
            count_q    <= '0;
            ctrl_out_q <= '0;
            type_out_q <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            ctrl_lat_q <= ctrl_lat_d;
            type_lat_q <= type_lat_d;
            count_q    <= count_d;
            ctrl_out_q <= ctrl_out_d;
            type_out_q <= type_out_d;
            data_out_q <= data_out_d;
        end
    end

`ifdef PU_LOAD_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wdog_q <= wdog_d;
            err_q  <= err_d;
        end
    end
    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    // desc_ready is gated by reset so it reads 0 while reset is held.
    assign bus.desc_ready     = reset && (state_q == ST_IDLE);
    assign bus.wr_ready       = (state_q == ST_LOAD);
    assign bus.busy           = (state_q != ST_IDLE);
    assign bus.start          = (state_q == ST_START);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.ctrl_mem_in    = ctrl_out_q;
    assign bus.mem_data_type  = type_out_q;
    assign bus.mem_data_input = data_out_q;
    assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_pu_load_ctrl.sv
// Self-checking bench for pu_load_ctrl: randomized descriptor/word streams scored against an expected write queue.
// Timeout scenario depends on PU_LOAD_CTRL_TIMEOUT_EN.
module tb_pu_load_ctrl;
  import pu_ctrl_pkg::*;

  localparam int MDL  = 16;
  localparam int COLS = 2;
  localparam int LPE  = 2;
  localparam int LNS  = 2;
  localparam int CL   = 12;
  localparam int TO   = 8;
  localparam int CW   = (LPE + 1) * COLS;
  localparam int DW   = MDL * COLS;
  localparam int WW   = CW + LNS + DW;
`ifdef PU_LOAD_CTRL_TIMEOUT_EN
  localparam int EOC_DELAY = 5;
`else
  localparam int EOC_DELAY = 20;
`endif

  logic clk;
  logic reset;
  pu_state_e dbg_state;
  int n_tests;
  int n_fail;
  logic [WW-1:0] exp_q[$];
  logic [DW-1:0] word_tbl[$];

  pu_load_ctrl_if #(.memDataLen(MDL), .numPuMemColumns(COLS), .logNumPeMemColumn(LPE),
                    .logMemNamespaces(LNS), .countLen(CL)) bus ();

  pu_load_ctrl #(.memDataLen(MDL), .numPuMemColumns(COLS), .logNumPeMemColumn(LPE),
                 .logMemNamespaces(LNS), .countLen(CL), .timeoutCycles(TO)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  // scoreboard: every PU write cycle must match the head of the expected queue
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.ctrl_mem_in !== '0) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: got %0h expected no write",
                 {bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input});
      end else begin
        logic [WW-1:0] e;
        e = exp_q.pop_front();
        if ({bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input} !== e) begin
          n_fail++;
          $display("FAIL sb_write: got %0h expected %0h",
                   {bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input}, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [CW-1:0] c, input logic [LNS-1:0] t,
                           input logic [CL-1:0] len, input logic with_go);
    n_tests++;
    if (bus.desc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL desc_ready: got %b expected 1", bus.desc_ready);
    end
    bus.desc_valid = 1'b1;
    bus.desc_ctrl  = c;
    bus.desc_type  = t;
    bus.desc_len   = len;
    bus.go         = with_go;
    tick();
    bus.desc_valid = 1'b0;
    n_tests++;
    if ({bus.busy, bus.wr_ready, bus.start} !== {len != 0, len != 0, 1'b0}) begin
      n_fail++;
      $display("FAIL desc_accept: got busy/wr_ready/start %b expected %b",
               {bus.busy, bus.wr_ready, bus.start}, {len != 0, len != 0, 1'b0});
    end
  endtask

  // gap_mode: 0 back-to-back, 1 one idle cycle between words, 2 random 0..3 idle cycles
  task automatic stream(input int n, input int total, input logic [CW-1:0] c,
                        input logic [LNS-1:0] t, input int gap_mode);
    logic [DW-1:0] w;
    logic [DW-1:0] last_w;
    int gap;
    last_w = '0;
    for (int i = 0; i < n; i++) begin
      if (i == 0 || gap_mode == 0) gap = 0;
      else if (gap_mode == 1) gap = 1;
      else gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        bus.wr_valid = 1'b0;
        tick();
        n_tests++;
        if ({bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input} !== {{CW{1'b0}}, t, last_w}) begin
          n_fail++;
          $display("FAIL gap_hold: got %0h expected %0h",
                   {bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input}, {{CW{1'b0}}, t, last_w});
        end
      end
      w = (word_tbl.size() != 0) ? word_tbl.pop_front() : DW'($urandom);
      n_tests++;
      if (bus.wr_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL wr_ready: got %b expected 1", bus.wr_ready);
      end
      bus.wr_valid = 1'b1;
      bus.wr_data  = w;
      exp_q.push_back({c, t, w});
      tick();
      n_tests++;
      if ({bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input} !== {c, t, w}) begin
        n_fail++;
        $display("FAIL write_latency: got %0h expected %0h",
                 {bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input}, {c, t, w});
      end
      n_tests++;
      if ({bus.busy, bus.start, bus.done} !== {(i + 1) < total, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL load_state: got busy/start/done %b expected %b",
                 {bus.busy, bus.start, bus.done}, {(i + 1) < total, 1'b0, 1'b0});
      end
      last_w = w;
    end
    bus.wr_valid = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_tests++;
    if ({bus.desc_ready, bus.wr_ready, bus.busy, bus.done, bus.err, bus.start,
         bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input} !== '0 || dbg_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: got %0h state %0d expected 0 state 0",
               {bus.desc_ready, bus.wr_ready, bus.busy, bus.done, bus.err, bus.start,
                bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input}, dbg_state);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_tests++;
    if ({bus.desc_ready, bus.busy, bus.wr_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL reset_release: got ready/busy/wr_ready %b expected 100",
               {bus.desc_ready, bus.busy, bus.wr_ready});
    end
  endtask

  task automatic test_inst_load();
    word_tbl = '{32'h0000_0010, 32'h0, 32'h0, 32'h0000_000A};
    send_desc(6'b000001, NS_INST, 12'd4, 1'b0);
    stream(4, 4, 6'b000001, NS_INST, 0);
    tick();
    n_tests++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0 || bus.ctrl_mem_in !== '0) begin
      n_fail++;
      $display("FAIL inst_load_end: got pending %0d busy %b ctrl %0h expected 0 0 0",
               exp_q.size(), bus.busy, bus.ctrl_mem_in);
    end
  endtask

  task automatic test_stall();
    logic [CW-1:0] c;
    c = CW'($urandom_range(1, (1 << CW) - 1));
    send_desc(c, NS_WEIGHT, 12'd3, 1'b0);
    stream(3, 3, c, NS_WEIGHT, 1);
    tick();
    n_tests++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_end: got pending %0d busy %b expected 0 0", exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_random_loads();
    for (int k = 0; k < 8; k++) begin
      logic [CW-1:0] c;
      logic [LNS-1:0] t;
      int len;
      c   = CW'($urandom_range(1, (1 << CW) - 1));
      t   = LNS'($urandom_range(0, 3));
      len = $urandom_range(1, 8);
      send_desc(c, t, CL'(len), 1'b0);
      stream(len, len, c, t, 2);
      repeat ($urandom_range(1, 3)) tick();
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL random_loads_pending: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_run();
    int starts;
    bus.inst_eoc = 1'b1;
    tick();
    bus.inst_eoc = 1'b0;
    tick();
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      n_fail++;
      $display("FAIL eoc_ignored_idle: got busy/done %b expected 00", {bus.busy, bus.done});
    end
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    starts = (bus.start === 1'b1) ? 1 : 0;
    n_tests++;
    if ({bus.start, bus.busy, bus.ctrl_mem_in} !== {2'b11, {CW{1'b0}}}) begin
      n_fail++;
      $display("FAIL start_pulse: got start/busy %b ctrl %0h expected 11 0",
               {bus.start, bus.busy}, bus.ctrl_mem_in);
    end
    for (int i = 0; i < EOC_DELAY + 1; i++) begin
      tick();
      if (bus.start === 1'b1) starts++;
    end
    n_tests++;
    if ({bus.busy, bus.done} !== 2'b10) begin
      n_fail++;
      $display("FAIL run_wait: got busy/done %b expected 10", {bus.busy, bus.done});
    end
    bus.inst_eoc = 1'b1;
    tick();
    bus.inst_eoc = 1'b0;
    n_tests++;
    if ({bus.done, bus.err, bus.busy} !== 3'b101) begin
      n_fail++;
      $display("FAIL done_pulse: got done/err/busy %b expected 101", {bus.done, bus.err, bus.busy});
    end
    tick();
    n_tests++;
    if ({bus.done, bus.busy, starts[1:0]} !== 4'b0001) begin
      n_fail++;
      $display("FAIL run_end: got done %b busy %b starts %0d expected 0 0 1", bus.done, bus.busy, starts);
    end
  endtask

  task automatic test_collision();
    logic [CW-1:0] c;
    c = CW'($urandom_range(1, (1 << CW) - 1));
    send_desc(c, NS_DATA, 12'd3, 1'b1);
    stream(3, 3, c, NS_DATA, 2);
    tick();
    bus.go = 1'b0;
    n_tests++;
    if ({bus.start, bus.busy} !== 2'b11) begin
      n_fail++;
      $display("FAIL collision_start: got start/busy %b expected 11", {bus.start, bus.busy});
    end
    tick();
    bus.inst_eoc = 1'b1;
    tick();
    bus.inst_eoc = 1'b0;
    tick();
    n_tests++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL collision_end: got pending %0d busy %b expected 0 0", exp_q.size(), bus.busy);
    end
    send_desc(c, NS_META, 12'd0, 1'b0);
    repeat (3) tick();
    n_tests++;
    if ({bus.busy, bus.desc_ready, bus.ctrl_mem_in} !== {2'b01, {CW{1'b0}}}) begin
      n_fail++;
      $display("FAIL empty_desc: got busy/ready %b ctrl %0h expected 01 0",
               {bus.busy, bus.desc_ready}, bus.ctrl_mem_in);
    end
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] c;
    c = CW'($urandom_range(1, (1 << CW) - 1));
    send_desc(c, NS_DATA, 12'd5, 1'b0);
    stream(2, 5, c, NS_DATA, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.desc_ready, bus.wr_ready, bus.busy, bus.done, bus.err, bus.start,
         bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input} !== '0) begin
      n_fail++;
      $display("FAIL midload_reset: got %0h expected 0",
               {bus.desc_ready, bus.wr_ready, bus.busy, bus.done, bus.err, bus.start,
                bus.ctrl_mem_in, bus.mem_data_type, bus.mem_data_input});
    end
    tick();
    @(negedge clk);
    reset = 1'b1;
    tick();
    n_tests++;
    if ({bus.desc_ready, bus.busy} !== 2'b10 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL midload_release: got ready/busy %b pending %0d expected 10 0",
               {bus.desc_ready, bus.busy}, exp_q.size());
    end
    send_desc(c, NS_WEIGHT, 12'd1, 1'b0);
    stream(1, 1, c, NS_WEIGHT, 0);
    repeat (2) tick();
    n_tests++;
    if (exp_q.size() != 0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_load: got pending %0d busy %b expected 0 0", exp_q.size(), bus.busy);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    n_tests++;
    if ({bus.busy, bus.err, bus.start} !== 3'b100) begin
      n_fail++;
      $display("FAIL run_entry: got busy/err/start %b expected 100", {bus.busy, bus.err, bus.start});
    end
`ifdef PU_LOAD_CTRL_TIMEOUT_EN
    cycles = 0;
    while (bus.done !== 1'b1 && cycles < 50) begin
      tick();
      cycles++;
    end
    n_tests++;
    if (cycles != TO || bus.err !== 1'b1) begin
      n_fail++;
      $display("FAIL watchdog: got %0d cycles err %b expected %0d cycles err 1", cycles, bus.err, TO);
    end
    tick();
    n_tests++;
    if ({bus.busy, bus.done, bus.err} !== 3'b001) begin
      n_fail++;
      $display("FAIL err_hold: got busy/done/err %b expected 001", {bus.busy, bus.done, bus.err});
    end
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    n_tests++;
    if ({bus.busy, bus.err} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_clear: got busy/err %b expected 10", {bus.busy, bus.err});
    end
`else
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.busy === 1'b1 && bus.err === 1'b0 && bus.done === 1'b0) cycles++;
    end
    n_tests++;
    if (cycles != 40) begin
      n_fail++;
      $display("FAIL no_watchdog: got %0d of 40 busy cycles without err expected 40", cycles);
    end
`endif
    bus.inst_eoc = 1'b1;
    tick();
    bus.inst_eoc = 1'b0;
    tick();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_end: got busy %b expected 0", bus.busy);
    end
  endtask

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    reset          = 1'b0;
    bus.desc_valid = 1'b0;
    bus.desc_ctrl  = '0;
    bus.desc_type  = '0;
    bus.desc_len   = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_data    = '0;
    bus.go         = 1'b0;
    bus.inst_eoc   = 1'b0;
    test_reset();
    test_inst_load();
    test_stall();
    test_random_loads();
    test_run();
    test_collision();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pu_load_ctrl.md
PU_LOAD_CTRL -- requirements
Module: pu_load_ctrl

Interface
REQ-001 SHALL have parameter memDataLen, default 16, width of one PE-column data word.
REQ-002 SHALL have parameter numPuMemColumns, default 2, number of PU memory columns written per cycle.
REQ-003 SHALL have parameter logNumPeMemColumn, default 2, log2 of the PE columns per PU memory column.
REQ-004 SHALL have parameter logMemNamespaces, default 2, namespace select width (0 instruction, 1 data, 2 weight, 3 meta).
REQ-005 SHALL have parameter countLen, default 12, descriptor word-count width.
REQ-006 SHALL have parameter timeoutCycles, default 4095, RUN watchdog limit.
REQ-007 SHALL have derived widths memDataLenIn = memDataLen*numPuMemColumns and memCtrlIn = (logNumPeMemColumn+1)*numPuMemColumns.
REQ-008 SHALL have ports: clk in 1, the single clock; reset in 1, asynchronous, active-low.
REQ-009 SHALL have descriptor ports: desc_valid in 1; desc_ready out 1; desc_ctrl in memCtrlIn, PE-column select; desc_type in logMemNamespaces; desc_len in countLen, word count.
REQ-010 SHALL have write-data ports: wr_valid in 1; wr_ready out 1; wr_data in memDataLenIn.
REQ-011 SHALL have host ports: go in 1, level request to run; busy out 1; done out 1, one-cycle pulse; err out 1, timeout flag.
REQ-012 SHALL have PU-facing ports: ctrl_mem_in out memCtrlIn; mem_data_type out logMemNamespaces; mem_data_input out memDataLenIn; start out 1; inst_eoc in 1.

Function
REQ-013 SHALL implement states IDLE, LOAD, START, RUN, DONE, with busy = (state != IDLE).
REQ-014 IDLE: desc_ready=1; on desc_valid, SHALL latch ctrl/type/len; len==0 stays IDLE, else goes to LOAD.
REQ-015 IDLE with go=1 and desc_valid=0 SHALL go to START; when both are high the descriptor wins and go is re-sampled next IDLE cycle.
REQ-016 LOAD: wr_ready=1, desc_ready=0; each wr_valid&&wr_ready handshake SHALL decrement the remaining count.
REQ-017 A word accepted at edge N SHALL appear on mem_data_input with ctrl_mem_in=latched ctrl and mem_data_type=latched type for exactly the cycle after edge N (1-cycle latency).
REQ-018 In any cycle without an accepted word, ctrl_mem_in SHALL be all-zero (no write); mem_data_input and mem_data_type hold their last values.
REQ-019 Acceptance of the last word (count 1) SHALL return to IDLE; wr_valid gaps SHALL stall without losing count.
REQ-020 START SHALL assert start for exactly one cycle with ctrl_mem_in=0, then enter RUN.
REQ-021 RUN SHALL wait for inst_eoc=1 and then enter DONE; inst_eoc outside RUN is ignored.
REQ-022 DONE SHALL pulse done for one cycle and return to IDLE; err keeps its value until the next START, which clears it.

Reset
REQ-023 reset low SHALL immediately force IDLE, count=0, ctrl_mem_in=0, mem_data_type=0, mem_data_input=0, start=0, done=0, err=0, busy=0, desc_ready=0, wr_ready=0.
REQ-024 A mid-LOAD or mid-RUN reset SHALL abandon the operation; after reset release, desc_ready=1 on the first clock.

Configuration
REQ-025 With PU_LOAD_CTRL_TIMEOUT_EN defined, a counter cleared on RUN entry SHALL, after timeoutCycles RUN cycles without inst_eoc, set err=1 and enter DONE.
REQ-026 Without PU_LOAD_CTRL_TIMEOUT_EN, err SHALL be tied 0, no watchdog counter SHALL exist, and RUN waits indefinitely.

Structure
REQ-027 State encoding and namespace constants (NS_INST, NS_DATA, NS_WEIGHT, NS_META) SHALL live in the shared package pu_ctrl_pkg.
REQ-028 SHALL be a single module with no sub-modules; the watchdog stays inline.

Verification
REQ-029 Instruction load: desc(ctrl=6'b1, type=0, len=4) with words 16'h0010,0,0,16'h000A back-to-back -> four consecutive cycles of ctrl_mem_in=6'b1 with those words, then IDLE.
REQ-030 Stalled stream: desc(len=3, type=2), wr_valid toggled 1,0,1,0,1 -> exactly 3 write cycles, ctrl_mem_in=0 in the gap cycles.
REQ-031 Run: go=1 from IDLE -> start high for exactly 1 cycle; inst_eoc after 20 cycles -> done pulses 1 cycle and err=0.
REQ-032 Collision and empty descriptor: desc_valid and go high together -> descriptor accepted first, start only after LOAD completes; desc(len=0) -> no write cycles.
REQ-033 Reset: reset low while 2 of 5 words are loaded -> all outputs 0 at once; new desc(len=1) after release writes exactly 1 word.
REQ-034 Timeout (macro on, timeoutCycles=8): no inst_eoc -> err=1 and done pulse 8 cycles after RUN entry; with macro off, err stays 0 and busy stays 1.
